// File: rtl/npu_res_wb.sv
// Writeback stage after the NPU datapath: requantizes W accumulated results to
// N-bit activations, packs them one nibble per lane, and drains them to memory.
module npu_res_wb #(
    parameter int N     = 2,
    parameter int BG    = 6,
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int SW    = 3
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic [AW-1:0]              cfg_base_addr,
    input  logic [SW-1:0]              cfg_shift,
    input  logic                       i_wr,
    input  logic [(N+BG)*W-1:0]        i_data,
    output logic                       o_mem_we,
    input  logic                       i_mem_ready,
    output logic [AW-1:0]              o_mem_addr,
    output logic [4*W-1:0]             o_mem_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_idle,
    output logic                       o_ovf
);

    localparam int RW = N + BG;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4*W-1:0] stage_q, stage_d;
    logic           stage_v_q, stage_v_d;
    logic [4*W-1:0] mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           ovf_q, ovf_d;
    logic [4*W-1:0] packed_w;
    logic           full, push, pop;

    function automatic logic [3:0] requant(input logic [RW-1:0] x, input logic [SW-1:0] sh);
        logic [RW:0] ext;
        logic [RW:0] rnd;
        logic [RW:0] y;
        logic [3:0]  r;
        ext = {1'b0, x};
        rnd = '0;
        if (sh != '0) rnd = (RW+1)'(1) << (sh - SW'(1));
        y = (ext + rnd) >> sh;
        r = '0;
        if (x[RW-1]) r = '0;
        else if (y > (RW+1)'((1 << N) - 1)) r = 4'((1 << N) - 1);
        else r = 4'(y[N-1:0]);
        return r;
    endfunction

    always_comb begin
        packed_w = '0;
        for (int unsigned l = 0; l < W; l++) begin
            packed_w[(W-1-l)*4 +: 4] = requant(i_data[(W-1-l)*RW +: RW], cfg_shift);
        end
    end

    always_comb begin
        full = (count_q == CW'(DEPTH));
        pop  = !cfg_start && (count_q != '0) && i_mem_ready;
        // A full FIFO still accepts the stage word when the head leaves this cycle.
        push = !cfg_start && stage_v_q && (!full || pop);

        stage_d   = stage_q;
        stage_v_d = stage_v_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        ovf_d     = ovf_q;

        if (cfg_start) begin
            stage_v_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            addr_d    = cfg_base_addr;
            ovf_d     = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                addr_d   = addr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            // A stuck stage word is kept; an incoming vector behind it is lost.
            if (stage_v_q && !push) begin
                if (i_wr) ovf_d = 1'b1;
            end else begin
                stage_v_d = i_wr;
                stage_d   = packed_w;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            stage_q   <= '0;
            stage_v_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            stage_v_q <= stage_v_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge ck) begin
        if (push) mem_q[wr_ptr_q] <= stage_q;
    end

    assign o_mem_we   = (count_q != '0);
    assign o_mem_data = o_mem_we ? mem_q[rd_ptr_q] : '0;
    assign o_mem_addr = addr_q;
    assign o_count    = count_q;
    assign o_idle     = !stage_v_q && (count_q == '0);
    assign o_ovf      = ovf_q;

endmodule
